cisr_row_sched: RTL and testbench

Front-end scheduler for the CISR SpMV datapath. It accepts one in-order stream of row lengths and distributes each row to a per-channel row-length FIFO. The distribution is exactly the order in which `cisr_acc` will consume rows: the next row goes to the lowest-indexed channel whose element counter has reached zero. To do this, the block keeps a shadow copy of every channel's element counter and steps those counters in lock-step slots.

---
 rtl/cisr_row_sched.sv | 149 ++++++++++++++
 tb/tb_cisr_row_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cisr_row_sched.sv
// Routes an in-order stream of row lengths to the channel that cisr_acc will free next.
// Define CISR_SCHED_TERM_EN to append one all-ones terminator per channel after the last row.
module cisr_row_sched #(
  parameter int channel_num     = 4,
  parameter int channel_num_log = 2,
  parameter int row_len_size    = 8,
  parameter int counter_size    = 8,
  parameter int row_id_size     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [row_id_size-1:0]              num_rows,
  input  logic [row_len_size-1:0]             in_len_data,
  input  logic                                in_len_valid,
  output logic                                in_len_ready,
  output logic [row_len_size*channel_num-1:0] row_len_fifo_wdata,
  output logic [channel_num-1:0]              row_len_fifo_write,
  input  logic [channel_num-1:0]              row_len_fifo_full,
  output logic                                busy,
  output logic                                done,
  output logic [row_id_size-1:0]              rows_sent
);

`ifdef CISR_SCHED_TERM_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TERM, S_DONE} state_t;
  localparam state_t S_TAIL = S_TERM;
  localparam logic [channel_num_log-1:0] LAST_CH = channel_num_log'(channel_num - 1);
  logic [channel_num_log-1:0] term_q, term_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                     state_q, state_d;
  logic [row_id_size-1:0]     num_rows_q, num_rows_d;
  logic [row_id_size-1:0]     rows_sent_q, rows_sent_d;
  logic [counter_size-1:0]    cnt_q [channel_num];
  logic [counter_size-1:0]    cnt_d [channel_num];
  logic [channel_num-1:0]     zero_vec;
  logic [channel_num_log-1:0] free_ch;
  logic [channel_num-1:0]     wr;
  logic [row_len_size-1:0]    wr_dat;

  // Descending scan so the lowest idle channel wins.
  always_comb begin
    zero_vec = '0;
    free_ch  = '0;
    for (int c = channel_num - 1; c >= 0; c--) begin
      if (cnt_q[c] == '0) begin
        zero_vec[c] = 1'b1;
        free_ch     = channel_num_log'(c);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    num_rows_d   = num_rows_q;
    rows_sent_d  = rows_sent_q;
    cnt_d        = cnt_q;
    wr           = '0;
    wr_dat       = in_len_data;
    in_len_ready = 1'b0;
`ifdef CISR_SCHED_TERM_EN
    term_d       = term_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d  = num_rows;
          rows_sent_d = '0;
          for (int c = 0; c < channel_num; c++) cnt_d[c] = '0;
`ifdef CISR_SCHED_TERM_EN
          term_d      = '0;
`endif
          state_d     = (num_rows == '0) ? S_TAIL : S_RUN;
        end
      end
      S_RUN: begin
        if (|zero_vec) begin
          if (in_len_valid && !row_len_fifo_full[free_ch]) begin
            in_len_ready    = 1'b1;
            wr[free_ch]     = 1'b1;
            cnt_d[free_ch]  = counter_size'(in_len_data);
            rows_sent_d     = rows_sent_q + row_id_size'(1);
            if (rows_sent_d == num_rows_q) state_d = S_TAIL;
          end
        end else begin
          // Every channel is mid-row: advance all of them by one element slot.
          for (int c = 0; c < channel_num; c++) cnt_d[c] = cnt_q[c] - counter_size'(1);
        end
      end
`ifdef CISR_SCHED_TERM_EN
      S_TERM: begin
        wr_dat = '1;
        if (!row_len_fifo_full[term_q]) begin
          wr[term_q] = 1'b1;
          if (term_q == LAST_CH) state_d = S_DONE;
          else                   term_d  = term_q + channel_num_log'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      wr           = '0;
      in_len_ready = 1'b0;
    end
  end

  always_comb begin
    row_len_fifo_wdata = '0;
    for (int c = 0; c < channel_num; c++) begin
      if (wr[c]) row_len_fifo_wdata[c*row_len_size +: row_len_size] = wr_dat;
    end
  end

  assign row_len_fifo_write = wr;
`ifdef CISR_SCHED_TERM_EN
  assign busy = (state_q == S_RUN) || (state_q == S_TERM);
`else
  assign busy = (state_q == S_RUN);
`endif
  assign done      = (state_q == S_DONE);
  assign rows_sent = rows_sent_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_rows_q  <= '0;
      rows_sent_q <= '0;
      for (int c = 0; c < channel_num; c++) cnt_q[c] <= '0;
`ifdef CISR_SCHED_TERM_EN
      term_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      rows_sent_q <= rows_sent_d;
      for (int c = 0; c < channel_num; c++) cnt_q[c] <= cnt_d[c];
`ifdef CISR_SCHED_TERM_EN
      term_q      <= term_d;
`endif
    end
  end

endmodule

// File: tb/tb_cisr_row_sched.sv
// Bench for cisr_row_sched: a timestamp model (channel free-at slot) checked every cycle,
// plus literal expectations on the dispatch order for the directed scenarios.
module tb_cisr_row_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_rows = '0;
  logic [7:0]  in_len_data = '0;
  logic        in_len_valid = 1'b0;
  logic        in_len_ready;
  logic [31:0] row_len_fifo_wdata;
  logic [3:0]  row_len_fifo_write;
  logic [3:0]  row_len_fifo_full = '0;
  logic        busy, done;
  logic [7:0]  rows_sent;

  cisr_row_sched dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .in_len_data(in_len_data), .in_len_valid(in_len_valid), .in_len_ready(in_len_ready),
    .row_len_fifo_wdata(row_len_fifo_wdata), .row_len_fifo_write(row_len_fifo_write),
    .row_len_fifo_full(row_len_fifo_full), .busy(busy), .done(done), .rows_sent(rows_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a channel is free once the slot count reaches the slot at which its row ends.
  typedef enum {M_IDLE, M_RUN, M_TERM, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int m_until [4] = '{0, 0, 0, 0};
  int m_slot = 0, m_sent = 0, m_nrows = 0, m_tidx = 0, m_steps = 0;

  // Observation log of DUT writes, done and busy cycles
  int log_ch[$];
  int log_dat[$];
  int log_cyc[$];
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0;

  always @(negedge clk) begin
    logic [3:0]  exp_wr;
    logic [31:0] exp_wd;
    logic        exp_rdy, exp_busy, exp_done;
    int          exp_sent, f;
    exp_wr = '0; exp_wd = '0; exp_rdy = 1'b0;
    exp_busy = (m_mode == M_RUN) || (m_mode == M_TERM);
    exp_done = (m_mode == M_DONE);
    exp_sent = m_sent;
    case (m_mode)
      M_IDLE: if (start) begin
        m_nrows = num_rows; m_sent = 0; m_slot = 0; m_tidx = 0;
        for (int c = 0; c < 4; c++) m_until[c] = 0;
`ifdef CISR_SCHED_TERM_EN
        m_mode = (num_rows == 0) ? M_TERM : M_RUN;
`else
        m_mode = (num_rows == 0) ? M_DONE : M_RUN;
`endif
      end
      M_RUN: begin
        f = -1;
        for (int c = 3; c >= 0; c--) if (m_until[c] <= m_slot) f = c;
        if (f < 0) begin
          m_slot++; m_steps++;
        end else if (in_len_valid && !row_len_fifo_full[f]) begin
          exp_rdy = 1'b1; exp_wr[f] = 1'b1; exp_wd[f*8 +: 8] = in_len_data;
          m_until[f] = m_slot + int'(in_len_data);
          m_sent++;
          if (m_sent == m_nrows) begin
`ifdef CISR_SCHED_TERM_EN
            m_mode = M_TERM;
`else
            m_mode = M_DONE;
`endif
          end
        end
      end
      M_TERM: if (!row_len_fifo_full[m_tidx]) begin
        exp_wr[m_tidx] = 1'b1; exp_wd[m_tidx*8 +: 8] = 8'hFF;
        if (m_tidx == 3) m_mode = M_DONE; else m_tidx++;
      end
      M_DONE: m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    if (rst) begin
      exp_wr = '0; exp_wd = '0; exp_rdy = 1'b0;
      m_mode = M_IDLE; m_sent = 0;
    end
    if (chk_en) begin
      chk("in_len_ready", 64'(in_len_ready), 64'(exp_rdy));
      chk("fifo_write", 64'(row_len_fifo_write), 64'(exp_wr));
      chk("fifo_wdata", 64'(row_len_fifo_wdata), 64'(exp_wd));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("rows_sent", 64'(rows_sent), 64'(exp_sent & 255));
      for (int c = 0; c < 4; c++) begin
        if (row_len_fifo_write[c]) begin
          log_ch.push_back(c);
          log_dat.push_back(int'(row_len_fifo_wdata[c*8 +: 8]));
          log_cyc.push_back(cyc);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
    end
  end

  logic [7:0] lq[$];
  int start_cyc = 0;

  task automatic clr_log();
    log_ch.delete(); log_dat.delete(); log_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; m_steps = 0;
  endtask

  function automatic logic [63:0] pack_ch(input int k);
    logic [63:0] r = '0;
    for (int i = 0; i < k && i < log_ch.size(); i++) r = (r << 4) | 64'(log_ch[i]);
    return r;
  endfunction

  function automatic logic [63:0] pack_dat(input int k);
    logic [63:0] r = '0;
    for (int i = 0; i < k && i < log_dat.size(); i++) r = (r << 8) | 64'(log_dat[i]);
    return r;
  endfunction

  // Called at posedge+1. abort_at >= 0 pulses rst in that RUN cycle and returns.
  task automatic run(input int n, input int full_cyc, input bit bubble, input int abort_at);
    int i = 0, t = 0;
    bit acc;
    clr_log();
    start_cyc = cyc;
    start = 1'b1; num_rows = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (i < n && t < 200) begin
      if (t == abort_at) rst = 1'b1;
      row_len_fifo_full = (t < full_cyc) ? 4'b0001 : 4'b0000;
      in_len_valid = bubble ? (t % 2 == 0) : 1'b1;
      in_len_data = lq[i];
      @(negedge clk);
      acc = in_len_ready && in_len_valid;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0; in_len_valid = 1'b0; row_len_fifo_full = '0;
        return;
      end
      if (acc) i++;
      t++;
    end
    in_len_valid = 1'b0; row_len_fifo_full = '0;
    if (i < n) chk("accept_timeout", 64'(i), 64'(n));
    t = 0;
    while (done_cnt == 0 && t < 50) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_len_ready), 64'd0);
    chk("rst_write", 64'(row_len_fifo_write), 64'd0);
    chk("rst_wdata", 64'(row_len_fifo_wdata), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_rows_sent", 64'(rows_sent), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic distribution
    lq = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd1};
    run(5, 0, 1'b0, -1);
    chk("basic_ch", pack_ch(5), 64'h01231);
    chk("basic_dat", pack_dat(5), 64'h0301020201);
    chk("basic_steps", 64'(m_steps), 64'd1);
    chk("basic_rows_sent", 64'(rows_sent), 64'd5);
`ifdef CISR_SCHED_TERM_EN
    chk("basic_busy_cycles", 64'(busy_cnt), 64'd10);
`else
    chk("basic_busy_cycles", 64'(busy_cnt), 64'd6);
    chk("basic_done_lat", 64'(done_cyc - start_cyc), 64'd7);
`endif

    // Zero-length rows stay on channel 0, back to back
    lq = '{8'd0, 8'd0, 8'd2};
    run(3, 0, 1'b0, -1);
    chk("zero_ch", pack_ch(3), 64'h000);
    chk("zero_dat", pack_dat(3), 64'h000002);
    chk("zero_consec", 64'(log_cyc[2] - log_cyc[0]), 64'd2);
    chk("zero_steps", 64'(m_steps), 64'd0);

    // Channel 0 full for the first 5 RUN cycles
    lq = '{8'd2, 8'd1};
    run(2, 5, 1'b0, -1);
    chk("full_first_lat", 64'(log_cyc[0] - start_cyc), 64'd6);
    chk("full_ch", pack_ch(2), 64'h01);

    // Input bubbles give the same assignment
    lq = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd1};
    run(5, 0, 1'b1, -1);
    chk("bubble_ch", pack_ch(5), 64'h01231);
    chk("bubble_dat", pack_dat(5), 64'h0301020201);
    chk("bubble_steps", 64'(m_steps), 64'd1);

    // Empty run
    lq.delete();
    run(0, 0, 1'b0, -1);
`ifdef CISR_SCHED_TERM_EN
    chk("empty_writes", 64'(log_ch.size()), 64'd4);
    chk("empty_done_lat", 64'(done_cyc - start_cyc), 64'd5);
`else
    chk("empty_writes", 64'(log_ch.size()), 64'd0);
    chk("empty_done_lat", 64'(done_cyc - start_cyc), 64'd1);
`endif

    // Reset in the third RUN cycle of a 10-row run
    lq = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    run(10, 0, 1'b0, 2);
    @(negedge clk);
    chk("abort_outputs", 64'({in_len_ready, row_len_fifo_write, busy, done}), 64'd0);
    chk("abort_wdata", 64'(row_len_fifo_wdata), 64'd0);
    chk("abort_rows_sent", 64'(rows_sent), 64'd0);
    chk("abort_writes", 64'(log_ch.size()), 64'd2);
    @(posedge clk); #1;
    lq = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd1};
    run(5, 0, 1'b0, -1);
    chk("restart_ch", pack_ch(5), 64'h01231);
    chk("restart_rows_sent", 64'(rows_sent), 64'd5);

`ifdef CISR_SCHED_TERM_EN
    // Terminators after a 2-row run
    lq = '{8'd1, 8'd1};
    run(2, 0, 1'b0, -1);
    chk("term_ch", pack_ch(6), 64'h010123);
    chk("term_dat", pack_dat(6), 64'h0101FFFFFFFF);
    chk("term_done_lat", 64'(done_cyc - log_cyc[5]), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
